// File: rtl/cnt_pkg.sv
// Shared types and constants for the parametrised up/down counter.
// Imported by the counter top level and its next-value sub-module.
package cnt_pkg;

    typedef enum logic {
        CNT_WRAP = 1'b0,
        CNT_SAT  = 1'b1
    } cnt_mode_e;

    localparam logic CNT_DIR_UP = 1'b1;
    localparam logic CNT_DIR_DN = 1'b0;

endpackage

// File: rtl/updn_next_val.sv
// Combinational successor of the count for one enabled step in the registered
// direction; flags a boundary event when the step leaves 0..MAX_VAL.
module updn_next_val
    import cnt_pkg::*;
#(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] MAX_VAL = '1,
    parameter cnt_mode_e        MODE    = CNT_WRAP
) (
    input  logic [WIDTH-1:0] count,
    input  logic             dir_q,
    output logic [WIDTH-1:0] next_count,
    output logic             boundary
);

    localparam logic [WIDTH:0] ONE_EXT = {{WIDTH{1'b0}}, 1'b1};
    localparam logic [WIDTH:0] MAX_EXT = {1'b0, MAX_VAL};

    logic [WIDTH:0] count_ext;
    logic [WIDTH:0] inc_ext;
    logic [WIDTH:0] dec_ext;

    // One extra bit so overflow past MAX_VAL and borrow below 0 are visible
    // without leaning on the natural 2**WIDTH rollover.
    assign count_ext = {1'b0, count};
    assign inc_ext   = count_ext + ONE_EXT;
    assign dec_ext   = count_ext - ONE_EXT;

    // NOTE: every output gets a default before the case, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        next_count = count;
        boundary   = 1'b0;
        case (dir_q)
            CNT_DIR_UP: begin
                if (inc_ext > MAX_EXT) begin
                    boundary   = 1'b1;
                    next_count = (MODE == CNT_WRAP) ? '0 : MAX_VAL;
                end else begin
                    next_count = inc_ext[WIDTH-1:0];
                end
            end
            CNT_DIR_DN: begin
                if (dec_ext[WIDTH]) begin
                    boundary   = 1'b1;
                    next_count = (MODE == CNT_WRAP) ? MAX_VAL : '0;
                end else begin
                    next_count = dec_ext[WIDTH-1:0];
                end
            end
        endcase
    end

endmodule

// File: rtl/updn_cnt_mod.sv
// Parametrised up/down counter: programmable modulus, wrap/saturate, clear,
// load, registered direction, terminal-count pulse and sticky overflow.
module updn_cnt_mod
    import cnt_pkg::*;
#(
    parameter int              WIDTH   = 4,
    parameter longint unsigned MAX_VAL = (64'd1 << WIDTH) - 64'd1,
    parameter cnt_mode_e       MODE    = CNT_WRAP,
    parameter longint unsigned RST_VAL = 64'd0
) (
    input  logic             cnt_clk,
    input  logic             cnt_rst,
    input  logic             cnt_en,
    input  logic             cnt_dir,
    input  logic             cnt_clr,
    input  logic             cnt_load,
    input  logic [WIDTH-1:0] cnt_load_val,
    output logic [WIDTH-1:0] count_out,
    output logic             cnt_tc,
    output logic             cnt_ovf
);

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("updn_cnt_mod: WIDTH must be within 2..32");
    end
    if (MAX_VAL < 64'd1 || MAX_VAL > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
        $error("updn_cnt_mod: MAX_VAL must be within 1..2**WIDTH-1");
    end
    if (RST_VAL > MAX_VAL) begin : g_bad_rst
        $error("updn_cnt_mod: RST_VAL must not exceed MAX_VAL");
    end

    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RST_W = WIDTH'(RST_VAL);

    logic [WIDTH-1:0] count_q, count_d;
    logic             dir_q, dir_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] step_val;
    logic             step_boundary;

    updn_next_val #(
        .WIDTH   (WIDTH),
        .MAX_VAL (MAX_W),
        .MODE    (MODE)
    ) u_next_val (
        .count      (count_q),
        .dir_q      (dir_q),
        .next_count (step_val),
        .boundary   (step_boundary)
    );

    // Priority: clear, then load, then an enabled count step, else hold.
    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        ovf_d   = ovf_q;
        dir_d   = cnt_dir;
        if (cnt_clr) begin
            count_d = RST_W;
            ovf_d   = 1'b0;
        end else if (cnt_load) begin
            count_d = (cnt_load_val > MAX_W) ? MAX_W : cnt_load_val;
        end else if (cnt_en) begin
            count_d = step_val;
            if (step_boundary) begin
                tc_d  = 1'b1;
                ovf_d = 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge cnt_clk or negedge cnt_rst) begin
        if (!cnt_rst) begin
            count_q <= RST_W;
            dir_q   <= CNT_DIR_UP;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            dir_q   <= dir_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count_out = count_q;
    assign cnt_tc    = tc_q;
    assign cnt_ovf   = ovf_q;

endmodule

// File: tb/tb_updn_cnt_mod.sv
// Self-checking bench: a wrap and a saturate instance share stimulus and are
// compared every cycle against an arithmetic model, plus literal checkpoints.
module tb_updn_cnt_mod;
    import cnt_pkg::*;

    localparam int W    = 4;
    localparam int MAXV = 9;
    localparam int RSTV = 0;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         en    = 1'b0;
    logic         dir   = 1'b1;
    logic         clr   = 1'b0;
    logic         load  = 1'b0;
    logic [W-1:0] lv    = '0;

    logic [W-1:0] cnt_w, cnt_s;
    logic         tc_w, tc_s, ovf_w, ovf_s;

    always #5 clk = ~clk;

    updn_cnt_mod #(.WIDTH(W), .MAX_VAL(MAXV), .MODE(CNT_WRAP), .RST_VAL(RSTV)) u_dut_wrap (
        .cnt_clk(clk), .cnt_rst(rst_n), .cnt_en(en), .cnt_dir(dir), .cnt_clr(clr),
        .cnt_load(load), .cnt_load_val(lv), .count_out(cnt_w), .cnt_tc(tc_w), .cnt_ovf(ovf_w)
    );

    updn_cnt_mod #(.WIDTH(W), .MAX_VAL(MAXV), .MODE(CNT_SAT), .RST_VAL(RSTV)) u_dut_sat (
        .cnt_clk(clk), .cnt_rst(rst_n), .cnt_en(en), .cnt_dir(dir), .cnt_clr(clr),
        .cnt_load(load), .cnt_load_val(lv), .count_out(cnt_s), .cnt_tc(tc_s), .cnt_ovf(ovf_s)
    );

    typedef struct {
        int cnt;
        bit tc;
        bit ovf;
    } model_t;

    model_t mw   = '{cnt: RSTV, tc: 1'b0, ovf: 1'b0};
    model_t ms   = '{cnt: RSTV, tc: 1'b0, ovf: 1'b0};
    bit     mdir = 1'b1;

    int checks   = 0;
    int failures = 0;
    bit cmp_on   = 1'b0;

    // Counts as plain integers: step by +/-1, and anything outside 0..MAXV is
    // a boundary event folded back by modulus (wrap) or pinned (saturate).
    function automatic model_t model_step(bit sat, model_t s, bit d, bit e, bit c, bit l, int v);
        model_t n;
        int     t;
        n    = s;
        n.tc = 1'b0;
        if (c) begin
            n.cnt = RSTV;
            n.ovf = 1'b0;
        end else if (l) begin
            n.cnt = (v > MAXV) ? MAXV : v;
        end else if (e) begin
            t = s.cnt + (d ? 1 : -1);
            if (t < 0 || t > MAXV) begin
                n.tc  = 1'b1;
                n.ovf = 1'b1;
                t = sat ? ((t < 0) ? 0 : MAXV) : (t + MAXV + 1) % (MAXV + 1);
            end
            n.cnt = t;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mw   <= '{cnt: RSTV, tc: 1'b0, ovf: 1'b0};
            ms   <= '{cnt: RSTV, tc: 1'b0, ovf: 1'b0};
            mdir <= 1'b1;
        end else begin
            mw   <= model_step(1'b0, mw, mdir, en, clr, load, int'(lv));
            ms   <= model_step(1'b1, ms, mdir, en, clr, load, int'(lv));
            mdir <= dir;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_on) begin
            check("wrap_count", 32'(cnt_w), 32'(mw.cnt));
            check("wrap_tc",    32'(tc_w),  32'(mw.tc));
            check("wrap_ovf",   32'(ovf_w), 32'(mw.ovf));
            check("sat_count",  32'(cnt_s), 32'(ms.cnt));
            check("sat_tc",     32'(tc_s),  32'(ms.tc));
            check("sat_ovf",    32'(ovf_s), 32'(ms.ovf));
        end
    end

    // Called at a falling edge: apply inputs, then return one falling edge later.
    task automatic step(input bit e, input bit d, input bit c, input bit l, input int v);
        en   = e;
        dir  = d;
        clr  = c;
        load = l;
        lv   = W'(v);
        @(negedge clk);
    endtask

    int t3_cnt[5] = '{8, 9, 9, 9, 9};
    int t3_tc[5]  = '{0, 0, 1, 1, 1};

    initial begin
        @(negedge clk);
        @(negedge clk);
        cmp_on = 1'b1;
        check("rst_count", 32'(cnt_w), 32'd0);
        check("rst_tc",    32'(tc_w),  32'd0);
        check("rst_ovf",   32'(ovf_w), 32'd0);
        rst_n = 1'b1;

        // Count up through the wrap.
        for (int i = 1; i <= 12; i++) begin
            step(1, 1, 0, 0, 0);
            if (i == 9)  check("t1_nine", 32'(cnt_w), 32'd9);
            if (i == 10) begin
                check("t1_wrap_cnt", 32'(cnt_w), 32'd0);
                check("t1_wrap_tc",  32'(tc_w),  32'd1);
                check("t1_wrap_ovf", 32'(ovf_w), 32'd1);
                check("t1_sat_pin",  32'(cnt_s), 32'd9);
                check("t1_sat_tc",   32'(tc_s),  32'd1);
            end
            if (i == 11) begin
                check("t1_tc_drop",   32'(tc_w),  32'd0);
                check("t1_ovf_stick", 32'(ovf_w), 32'd1);
            end
            if (i == 12) check("t1_twelve", 32'(cnt_w), 32'd2);
        end

        // Direction change lags one cycle, then down through the wrap.
        step(0, 1, 0, 1, 5);
        check("t2_load5", 32'(cnt_w), 32'd5);
        step(1, 0, 0, 0, 0);
        check("t2_lag", 32'(cnt_w), 32'd6);
        step(1, 0, 0, 0, 0);
        check("t2_down", 32'(cnt_w), 32'd5);
        for (int k = 0; k < 5; k++) step(1, 0, 0, 0, 0);
        check("t2_zero", 32'(cnt_w), 32'd0);
        step(1, 0, 0, 0, 0);
        check("t2_wrap_cnt", 32'(cnt_w), 32'd9);
        check("t2_wrap_tc",  32'(tc_w),  32'd1);
        check("t2_sat_zero", 32'(cnt_s), 32'd0);
        check("t2_sat_tc",   32'(tc_s),  32'd1);

        // Saturate pinned at the top re-pulses tc.
        step(0, 1, 0, 1, 7);
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 0, 0, 0);
            check("t3_sat_cnt", 32'(cnt_s), 32'(t3_cnt[i]));
            check("t3_sat_tc",  32'(tc_s),  32'(t3_tc[i]));
        end

        // Load clamps and beats enable.
        step(1, 1, 0, 1, 14);
        check("t4_clamp",    32'(cnt_w), 32'd9);
        check("t4_clamp_tc", 32'(tc_w),  32'd0);
        step(0, 1, 0, 1, 3);
        check("t4_load3", 32'(cnt_w), 32'd3);

        // Clear beats load and a due wrap.
        step(0, 1, 0, 1, 9);
        step(1, 1, 1, 1, 5);
        check("t5_clr_cnt", 32'(cnt_w), 32'd0);
        check("t5_clr_tc",  32'(tc_w),  32'd0);
        check("t5_clr_ovf", 32'(ovf_w), 32'd0);

        // Asynchronous reset mid-cycle.
        step(0, 1, 0, 1, 9);
        step(1, 1, 0, 0, 0);
        for (int k = 0; k < 6; k++) step(1, 1, 0, 0, 0);
        check("t6_pre_cnt", 32'(cnt_w), 32'd6);
        check("t6_pre_ovf", 32'(ovf_w), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_cnt", 32'(cnt_w), 32'd0);
        check("t6_async_ovf", 32'(ovf_w), 32'd0);
        check("t6_async_tc",  32'(tc_w),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_resume1", 32'(cnt_w), 32'd1);
        @(negedge clk);
        check("t6_resume2", 32'(cnt_w), 32'd2);

        // Randomised traffic, including rare mid-cycle reset pulses.
        for (int n = 0; n < 3000; n++) begin
            en   = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) dir = ~dir;
            clr  = ($urandom_range(0, 31) == 0);
            load = ($urandom_range(0, 15) == 0);
            lv   = W'($urandom_range(0, 15));
            if ($urandom_range(0, 199) == 0) begin
                #2 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
            @(negedge clk);
        end

        cmp_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/updn_cnt_mod.md
Name: updn_cnt_mod

Overview:
- Parametrised successor to the fixed 4-bit up/down counter.
- Adds generic width, a programmable modulus, wrap or saturate mode, enable, synchronous clear, parallel load, a terminal-count pulse and a sticky overflow flag.
- Used as a general event/position counter and as a modulo divider in control datapaths.
- Keeps the registered-direction behaviour: a direction change takes effect one cycle after it is sampled.

Parameters:
- WIDTH, 4, counter width in bits (2..32).
- MAX_VAL, 2**WIDTH-1, highest count value (modulus is MAX_VAL+1); must be >= 1 and <= 2**WIDTH-1.
- MODE, CNT_WRAP, CNT_WRAP wraps at the boundaries; CNT_SAT holds at the boundaries.
- RST_VAL, 0, value count_out takes on reset and on clear; must be <= MAX_VAL.

Ports:
- cnt_clk, in, 1, clock; all state updates on the rising edge.
- cnt_rst, in, 1, asynchronous active-low reset.
- cnt_en, in, 1, count enable; when low, count_out holds.
- cnt_dir, in, 1, direction request (1 = up, 0 = down); registered before use.
- cnt_clr, in, 1, synchronous clear to RST_VAL; also clears cnt_ovf.
- cnt_load, in, 1, synchronous parallel load.
- cnt_load_val, in, WIDTH, value to load.
- count_out, out, WIDTH, current count.
- cnt_tc, out, 1, registered one-cycle pulse, high in the cycle after a boundary event.
- cnt_ovf, out, 1, sticky flag set by any boundary event; cleared by cnt_clr or reset.

Behaviour:
- Reset (cnt_rst low, asynchronous):
  - count_out = RST_VAL, dir_q = 1 (up), cnt_tc = 0, cnt_ovf = 0.
  - Takes effect immediately, including mid-count. Release is sampled on the next rising edge.
- Direction register:
  - dir_q <= cnt_dir every cycle, regardless of cnt_en.
  - Counting uses dir_q, so a cnt_dir change affects the count one cycle later.
- Priority per edge: cnt_clr > cnt_load > cnt_en count > hold.
- Clear:
  - count_out <= RST_VAL, cnt_ovf <= 0, cnt_tc <= 0.
- Load:
  - count_out <= min(cnt_load_val, MAX_VAL); out-of-range values clamp to MAX_VAL.
  - cnt_tc <= 0; cnt_ovf unchanged.
- Count up (cnt_en = 1, dir_q = 1):
  - count_out < MAX_VAL: count_out + 1.
  - count_out = MAX_VAL, CNT_WRAP: count_out <= 0 (boundary event).
  - count_out = MAX_VAL, CNT_SAT: hold at MAX_VAL (boundary event).
- Count down (cnt_en = 1, dir_q = 0):
  - count_out > 0: count_out - 1.
  - count_out = 0, CNT_WRAP: count_out <= MAX_VAL (boundary event).
  - count_out = 0, CNT_SAT: hold at 0 (boundary event).
- Boundary event:
  - cnt_tc <= 1 for exactly one cycle; cnt_ovf <= 1 (sticky).
  - In CNT_SAT, cnt_tc re-pulses on every enabled cycle spent pinned at the boundary.
- Not counting (cnt_en = 0, no clear/load): count_out holds, cnt_tc <= 0.
- Arithmetic:
  - Compute in WIDTH+1 bits; no reliance on natural 2**WIDTH rollover.
  - Non-power-of-two MAX_VAL must wrap exactly at MAX_VAL.
- Simultaneous events:
  - cnt_load and cnt_en together: load wins, no count, no boundary event.
  - cnt_clr together with a would-be boundary event: cnt_ovf ends at 0.
- Latency: count_out, cnt_tc and cnt_ovf are all registered; no combinational path from inputs to outputs.

Decomposition:
- Package cnt_pkg:
  - typedef enum logic {CNT_WRAP, CNT_SAT} cnt_mode_e.
  - Constants CNT_DIR_UP = 1'b1 and CNT_DIR_DN = 1'b0.
- Sub-module updn_next_val (purely combinational):
  - Inputs: current count, dir_q, MAX_VAL, MODE.
  - Outputs: next count and a boundary flag.
  - Top level holds the registers and the clear/load/enable priority logic.
- Elaboration-time assertions check the MAX_VAL and RST_VAL ranges.

Test Plan (WIDTH=4, MAX_VAL=9, MODE=CNT_WRAP unless stated):
1. Reset, then cnt_en=1, cnt_dir=1 for 12 cycles -> count 0,1,...,9,0,1; cnt_tc high exactly in the cycle count shows 0 after 9; cnt_ovf=1 from then on.
2. From count=5 with cnt_en=1, toggle cnt_dir to 0 -> one more increment to 6 (direction lag), then 5, 4, ...; from 0 wraps to 9 with a cnt_tc pulse.
3. MODE=CNT_SAT, up from 7 for 5 cycles -> 8, 9, 9, 9, 9; cnt_tc pulses on each pinned cycle; count never reaches 0.
4. cnt_load=1 with cnt_load_val=14 and cnt_en=1 -> count=9 next cycle (clamped), no cnt_tc; cnt_load_val=3 -> count=3.
5. cnt_clr=1 together with cnt_load=1 at count=9 while a wrap is due -> count=RST_VAL=0, cnt_tc=0, cnt_ovf=0.
6. Assert cnt_rst low asynchronously mid-cycle at count=6 -> count_out=0, cnt_ovf=0, cnt_tc=0 immediately; after release, counting resumes upward on the following edges.
